stb_seq_ctrl: RTL

Controller that shares the strobe-timing unit (STB in, TL/TS out) between two requesters. Per accepted request it:
- resets the unit;
- drives a programmed STB low phase and then a programmed STB high phase;
- measures in which high-phase cycle TL and TS rise;
- returns the result on a one-cycle response.

It sits between the test-environment command logic and the timing unit, and it is the only driver of the unit's STB and reset pins.

---
 rtl/stb_seq_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/stb_seq_ctrl.sv
// stb_seq_ctrl: shares the strobe-timing unit between two requesters.
// Per accepted command: pulse the unit reset, drive STB low then high for the
// programmed lengths, record the high-phase cycle of the first TL/TS rise,
// then issue a one-cycle response.
// Optional: define STB_SEQ_ABORT_EN to add the abort input / rsp_abort output.
module stb_seq_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [CNT_W-1:0] req0_low,
    input  logic [CNT_W-1:0] req0_high,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [CNT_W-1:0] req1_low,
    input  logic [CNT_W-1:0] req1_high,
    output logic             req1_ready,
    output logic             stb,
    output logic             unit_rst_n,
    input  logic             tl,
    input  logic             ts,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic             rsp_tl_ok,
    output logic             rsp_ts_ok,
    output logic [CNT_W-1:0] rsp_tl_cyc,
    output logic [CNT_W-1:0] rsp_ts_cyc,
`ifdef STB_SEQ_ABORT_EN
    input  logic             abort,
    output logic             rsp_abort,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, CLR, LOW, HIGH, RESP} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] low;
        logic [CNT_W-1:0] high;
    } cmd_t;

    state_t           state, state_nx;
    cmd_t             cmd_q, cmd_nx;
    logic [CNT_W-1:0] cnt;
    logic             last_grant, tl_d, ts_d;
    logic             grant0, grant1, accept, abort_hit, in_phase;

    // Round-robin between the two requesters; zero lengths promoted to 1
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        cmd_nx.low  = grant1 ? req1_low  : req0_low;
        cmd_nx.high = grant1 ? req1_high : req0_high;
        if (cmd_nx.low == '0)  cmd_nx.low  = ONE;
        if (cmd_nx.high == '0) cmd_nx.high = ONE;
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign busy       = (state != IDLE);
    assign in_phase   = (state == CLR) | (state == LOW) | (state == HIGH);

`ifdef STB_SEQ_ABORT_EN
    assign abort_hit = abort & in_phase;
`else
    assign abort_hit = 1'b0;
`endif

    // Next-state logic; abort short-circuits any active phase to RESP
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = CLR;
            CLR:     state_nx = LOW;
            LOW:     if (cnt == cmd_q.low - ONE)  state_nx = HIGH;
            HIGH:    if (cnt == cmd_q.high - ONE) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort_hit) state_nx = RESP;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Registered pin drive, phase counter, command latch and edge capture
    always_ff @(posedge clk) begin
        if (rst) begin
            stb        <= 1'b1;
            unit_rst_n <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_tl_ok  <= 1'b0;
            rsp_ts_ok  <= 1'b0;
            rsp_tl_cyc <= '0;
            rsp_ts_cyc <= '0;
            last_grant <= 1'b1;
            tl_d       <= 1'b1;
            ts_d       <= 1'b1;
            cnt        <= '0;
            cmd_q      <= '0;
`ifdef STB_SEQ_ABORT_EN
            rsp_abort  <= 1'b0;
`endif
        end else begin
            // Outputs follow the state being entered so they align with it
            stb        <= (state_nx != LOW);
            unit_rst_n <= (state_nx != CLR);
            rsp_valid  <= (state_nx == RESP);
            tl_d       <= tl;
            ts_d       <= ts;
            // cnt restarts at every phase boundary; it doubles as hc in HIGH
            if ((state_nx != state) || !((state == LOW) || (state == HIGH)))
                cnt <= '0;
            else
                cnt <= cnt + ONE;
            if (accept) begin
                cmd_q      <= cmd_nx;
                rsp_id     <= grant1;
                last_grant <= grant1;
                rsp_tl_ok  <= 1'b0;
                rsp_ts_ok  <= 1'b0;
                rsp_tl_cyc <= '0;
                rsp_ts_cyc <= '0;
`ifdef STB_SEQ_ABORT_EN
                rsp_abort  <= 1'b0;
`endif
            end else if (state == HIGH) begin
                // Only the first rise of each signal in the high phase counts
                if (tl & ~tl_d & ~rsp_tl_ok) begin
                    rsp_tl_ok  <= 1'b1;
                    rsp_tl_cyc <= cnt;
                end
                if (ts & ~ts_d & ~rsp_ts_ok) begin
                    rsp_ts_ok  <= 1'b1;
                    rsp_ts_cyc <= cnt;
                end
            end
`ifdef STB_SEQ_ABORT_EN
            if (abort_hit) rsp_abort <= 1'b1;
`endif
        end
    end

endmodule
